multi_shift_reg: RTL

Parametrised universal shift register and the successor to the single-step shift latch. Supports parallel load, clear, and logical, arithmetic and rotate shifts in both directions, with serial in and serial out. Adds a multi-cycle "shift by N" command with a busy/done handshake, so datapath FSMs can issue one command and wait for completion. Sits beside the general-purpose latches in the shared datapath library.

---
 rtl/multi_shift_reg_pkg.sv | 30 +++
 rtl/multi_shift_reg_if.sv | 32 +++
 rtl/multi_shift_reg_shift_step.sv | 46 ++++
 rtl/multi_shift_reg.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/multi_shift_reg_pkg.sv
// Shared types for the multi-step universal shift register: operation and FSM state encodings.
package msr_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    SHL   = 3'd3,
    SHR   = 3'd4,
    ASR   = 3'd5,
    ROL   = 3'd6,
    ROR   = 3'd7
  } msr_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } msr_state_t;

  function automatic logic is_shift(input msr_op_t op);
    logic res;
    case (op)
      SHL, SHR, ASR, ROL, ROR: res = 1'b1;
      default:                 res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/multi_shift_reg_if.sv
// Command/data bundle of multi_shift_reg; carry is present only when MSR_CARRY_EN is defined.
interface multi_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) ();
  import msr_pkg::*;

  logic             en;
  msr_op_t          op;
  logic [WIDTH-1:0] D;
  logic [CNT_W-1:0] amount;
  logic             start;
  logic             serial_in;
  logic [WIDTH-1:0] Q;
  logic             serial_out;
  logic             busy;
  logic             done;
`ifdef MSR_CARRY_EN
  logic             carry;

  modport master (output en, op, D, amount, start, serial_in,
                  input  Q, serial_out, busy, done, carry);
  modport slave  (input  en, op, D, amount, start, serial_in,
                  output Q, serial_out, busy, done, carry);
`else
  modport master (output en, op, D, amount, start, serial_in,
                  input  Q, serial_out, busy, done);
  modport slave  (input  en, op, D, amount, start, serial_in,
                  output Q, serial_out, busy, done);
`endif

endinterface

// File: rtl/multi_shift_reg_shift_step.sv
// One-position shift/rotate of a register value; non-shift ops pass the value through.
module msr_shift_step
  import msr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  msr_op_t          op,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q_next,
  output logic             shift_out
);

  // Next value and the bit leaving the register for the given op
  always_comb begin
    q_next    = q;
    shift_out = 1'b0;
    case (op)
      SHL: begin
        q_next    = {q[WIDTH-2:0], serial_in};
        shift_out = q[WIDTH-1];
      end
      SHR: begin
        q_next    = {serial_in, q[WIDTH-1:1]};
        shift_out = q[0];
      end
      ASR: begin
        q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
        shift_out = q[0];
      end
      ROL: begin
        q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
        shift_out = q[WIDTH-1];
      end
      ROR: begin
        q_next    = {q[0], q[WIDTH-1:1]};
        shift_out = q[0];
      end
      default: begin
        q_next    = q;
        shift_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multi_shift_reg.sv
// Universal shift register with single-step ops and a multi-cycle "shift by N" command.
// Optional MSR_CARRY_EN adds a carry register holding the last bit shifted out.
module multi_shift_reg
  import msr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic       clock,
  input  logic       reset,
  multi_shift_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  msr_state_t       state_r, state_n_s;
  logic [CNT_W-1:0] cnt_r, cnt_n_s;
  msr_op_t          lop_r, lop_n_s;
  msr_op_t          act_op_s;
  logic [WIDTH-1:0] q_r, q_n_s, step_q_s;
  logic             step_out_s;
  logic             busy_r, done_r;
`ifdef MSR_CARRY_EN
  logic             carry_r, carry_n_s;
`endif

  // The latched op drives the shifter while a multi-cycle shift is running
  always_comb begin
    if (state_r == RUN) begin
      act_op_s = lop_r;
    end else begin
      act_op_s = bus.op;
    end
  end

  msr_shift_step #(.WIDTH(WIDTH)) u_step (
    .q         (q_r),
    .op        (act_op_s),
    .serial_in (bus.serial_in),
    .q_next    (step_q_s),
    .shift_out (step_out_s)
  );

  // Next-state, counter, latched op and datapath selection
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    lop_n_s   = lop_r;
    q_n_s     = q_r;
`ifdef MSR_CARRY_EN
    carry_n_s = carry_r;
`endif
    case (state_r)
      IDLE, DONE: begin
        state_n_s = IDLE;
        if (bus.start && is_shift(bus.op)) begin
          lop_n_s = bus.op;
          cnt_n_s = bus.amount;
          if (bus.amount == CNT_ZERO) begin
            state_n_s = DONE;
          end else begin
            state_n_s = RUN;
          end
        end else begin
          case (bus.op)
            LOAD: begin
              q_n_s = bus.D;
`ifdef MSR_CARRY_EN
              carry_n_s = 1'b0;
`endif
            end
            CLEAR: begin
              q_n_s = {WIDTH{1'b0}};
`ifdef MSR_CARRY_EN
              carry_n_s = 1'b0;
`endif
            end
            SHL, SHR, ASR, ROL, ROR: begin
              q_n_s = step_q_s;
`ifdef MSR_CARRY_EN
              carry_n_s = step_out_s;
`endif
            end
            default: q_n_s = q_r;
          endcase
        end
      end
      RUN: begin
        q_n_s   = step_q_s;
        cnt_n_s = cnt_r - CNT_ONE;
`ifdef MSR_CARRY_EN
        carry_n_s = step_out_s;
`endif
        if (cnt_r == CNT_ONE) begin
          state_n_s = DONE;
        end else begin
          state_n_s = RUN;
        end
      end
      default: begin
        state_n_s = IDLE;
        cnt_n_s   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers; en low freezes everything
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      lop_r   <= HOLD;
      q_r     <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef MSR_CARRY_EN
      carry_r <= 1'b0;
`endif
    end else if (bus.en) begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      lop_r   <= lop_n_s;
      q_r     <= q_n_s;
      busy_r  <= (state_n_s == RUN);
      done_r  <= (state_n_s == DONE);
`ifdef MSR_CARRY_EN
      carry_r <= carry_n_s;
`endif
    end
  end

  assign bus.Q          = q_r;
  assign bus.serial_out = step_out_s;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
`ifdef MSR_CARRY_EN
  assign bus.carry      = carry_r;
`endif

endmodule
